// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: the pipeline writeback always wins, and mul/div
// results queue in a small FIFO. A busy scoreboard tracks destinations whose mul/div result is still outstanding.
module regfile_wb_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_valid,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic        md_valid,
  output logic        md_ready,
  input  logic [4:0]  md_addr,
  input  logic [31:0] md_data,
  input  logic        md_issue_valid,
  input  logic [4:0]  md_issue_addr,
  input  logic [4:0]  src_a,
  input  logic [4:0]  src_b,
  output logic        busy_a,
  output logic        busy_b,
  output logic        pipe_hold,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        err
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int WW = $clog2(STARVE_LIMIT + 1);

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } md_ent_t;

  md_ent_t [DEPTH-1:0] mem_q, mem_d;
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic [WW-1:0]       wait_cnt_q, wait_cnt_d;
  logic                pipe_hold_q, pipe_hold_d;
  logic [31:0]         busy_q, busy_d;
  logic                rf_we_q, rf_we_d;
  logic [4:0]          rf_waddr_q, rf_waddr_d;
  logic [31:0]         rf_wdata_q, rf_wdata_d;
  logic                md_src_q, md_src_d;
  logic                err_q, err_d;

  logic    fifo_empty, fifo_full, push, pop;
  md_ent_t head;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CW'(DEPTH));
  // Readiness looks only at registered occupancy, so a same-cycle pop never opens a slot early.
  assign md_ready   = !rst && !fifo_full;
  assign push       = md_valid && md_ready;
  assign pop        = !wb_valid && !fifo_empty;
  assign head       = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = '{addr: md_addr, data: md_data};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop)
      rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (fifo_empty || pop)
      wait_cnt_d = '0;
    else if (wait_cnt_q != WW'(STARVE_LIMIT))
      wait_cnt_d = wait_cnt_q + 1'b1;
    pipe_hold_d = (wait_cnt_d == WW'(STARVE_LIMIT));
  end

  // The winner is registered even when its address is 0; only rf_we masks the write.
  always_comb begin
    rf_we_d    = 1'b0;
    rf_waddr_d = '0;
    rf_wdata_d = '0;
    md_src_d   = 1'b0;
    if (wb_valid) begin
      rf_we_d    = (wb_addr != '0);
      rf_waddr_d = wb_addr;
      rf_wdata_d = wb_data;
    end else if (pop) begin
      rf_we_d    = (head.addr != '0);
      rf_waddr_d = head.addr;
      rf_wdata_d = head.data;
      md_src_d   = (head.addr != '0);
    end
  end

  // The clear lags the write by a cycle to cover the register file's registered read.
  always_comb begin
    busy_d = busy_q;
    if (rf_we_q && md_src_q)
      busy_d[rf_waddr_q] = 1'b0;
    if (md_issue_valid && md_issue_addr != '0)
      busy_d[md_issue_addr] = 1'b1;
  end

  always_comb begin
    err_d = err_q;
    if (md_issue_valid && md_issue_addr != '0 && busy_q[md_issue_addr])
      err_d = 1'b1;
    if (wb_valid && wb_addr != '0 && busy_q[wb_addr])
      err_d = 1'b1;
  end

  always_ff @(posedge clk)
    mem_q <= mem_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      wait_cnt_q  <= '0;
      pipe_hold_q <= 1'b0;
      busy_q      <= '0;
      rf_we_q     <= 1'b0;
      rf_waddr_q  <= '0;
      rf_wdata_q  <= '0;
      md_src_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      wait_cnt_q  <= wait_cnt_d;
      pipe_hold_q <= pipe_hold_d;
      busy_q      <= busy_d;
      rf_we_q     <= rf_we_d;
      rf_waddr_q  <= rf_waddr_d;
      rf_wdata_q  <= rf_wdata_d;
      md_src_q    <= md_src_d;
      err_q       <= err_d;
    end
  end

  assign busy_a    = busy_q[src_a];
  assign busy_b    = busy_q[src_b];
  assign pipe_hold = pipe_hold_q;
  assign rf_we     = rf_we_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_wdata  = rf_wdata_q;
  assign err       = err_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter (DEPTH=2, STARVE_LIMIT=4); expected values hand-derived per cycle.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        md_valid, md_ready;
  logic [4:0]  md_addr;
  logic [31:0] md_data;
  logic        md_issue_valid;
  logic [4:0]  md_issue_addr;
  logic [4:0]  src_a, src_b;
  logic        busy_a, busy_b, pipe_hold, rf_we, err;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  int n_tests = 0;
  int n_fail  = 0;

  regfile_wb_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .md_valid(md_valid), .md_ready(md_ready), .md_addr(md_addr), .md_data(md_data),
    .md_issue_valid(md_issue_valid), .md_issue_addr(md_issue_addr),
    .src_a(src_a), .src_b(src_b), .busy_a(busy_a), .busy_b(busy_b),
    .pipe_hold(pipe_hold), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  // Advance one clock; sample point is 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wb_valid = 0; wb_addr = 0; wb_data = 0;
    md_valid = 0; md_addr = 0; md_data = 0;
    md_issue_valid = 0; md_issue_addr = 0;
  endtask

  initial begin
    idle_inputs();
    src_a = 0; src_b = 0;
    rst = 1;
    step();
    chk("rst_md_ready", 32'(md_ready), 0);
    step();
    rst = 0;
    #1;
    chk("post_rst_md_ready", 32'(md_ready), 1);
    chk("post_rst_rf_we", 32'(rf_we), 0);
    chk("post_rst_rf_waddr", 32'(rf_waddr), 0);
    chk("post_rst_rf_wdata", rf_wdata, 0);
    chk("post_rst_hold", 32'(pipe_hold), 0);
    chk("post_rst_err", 32'(err), 0);
    chk("post_rst_busy_a", 32'(busy_a), 0);

    // Pipeline write: one cycle latency
    wb_valid = 1; wb_addr = 5; wb_data = 32'hDEADBEEF;
    step();
    idle_inputs();
    chk("wb_we", 32'(rf_we), 1);
    chk("wb_waddr", 32'(rf_waddr), 5);
    chk("wb_wdata", rf_wdata, 32'hDEADBEEF);
    step();
    chk("wb_we_drop", 32'(rf_we), 0);

    // Mul/div path and scoreboard timing (t = issue cycle)
    src_a = 9; src_b = 9;
    md_issue_valid = 1; md_issue_addr = 9;
    step();                                   // t+1
    idle_inputs();
    chk("md_busy_t1", 32'(busy_a), 1);
    chk("md_busy_b_t1", 32'(busy_b), 1);
    step();                                   // t+2
    step();                                   // t+3
    md_valid = 1; md_addr = 9; md_data = 32'h12345678;
    chk("md_ready_t3", 32'(md_ready), 1);
    step();                                   // t+4
    idle_inputs();
    chk("md_we_t4", 32'(rf_we), 0);
    chk("md_busy_t4", 32'(busy_a), 1);
    step();                                   // t+5
    chk("md_we_t5", 32'(rf_we), 1);
    chk("md_waddr_t5", 32'(rf_waddr), 9);
    chk("md_wdata_t5", rf_wdata, 32'h12345678);
    chk("md_busy_t5", 32'(busy_a), 1);
    step();                                   // t+6
    chk("md_busy_t6", 32'(busy_a), 0);
    chk("md_we_t6", 32'(rf_we), 0);

    // FIFO fill under continuous wb, starvation hold, drain order (p = first push)
    wb_valid = 1; wb_addr = 1; wb_data = 32'h11;
    md_valid = 1; md_addr = 10; md_data = 32'hA1;
    step();                                   // p+1
    chk("fill_ready_p1", 32'(md_ready), 1);
    md_addr = 11; md_data = 32'hA2;
    step();                                   // p+2
    md_valid = 0;
    chk("fill_ready_p2", 32'(md_ready), 0);
    chk("fill_wb_we", 32'(rf_we), 1);
    chk("fill_wb_waddr", 32'(rf_waddr), 1);
    step();                                   // p+3
    step();                                   // p+4
    chk("hold_p4", 32'(pipe_hold), 0);
    step();                                   // p+5
    chk("hold_p5", 32'(pipe_hold), 1);
    chk("hold_ready_p5", 32'(md_ready), 0);
    wb_valid = 0;
    step();                                   // p+6
    chk("drain1_we", 32'(rf_we), 1);
    chk("drain1_waddr", 32'(rf_waddr), 10);
    chk("drain1_wdata", rf_wdata, 32'hA1);
    chk("drain1_hold", 32'(pipe_hold), 0);
    chk("drain1_ready", 32'(md_ready), 1);
    step();                                   // p+7
    chk("drain2_waddr", 32'(rf_waddr), 11);
    chk("drain2_wdata", rf_wdata, 32'hA2);
    step();                                   // p+8
    chk("drain_idle_we", 32'(rf_we), 0);

    // wb wins over an existing FIFO head
    wb_valid = 1; wb_addr = 2; wb_data = 32'h22;
    md_valid = 1; md_addr = 4; md_data = 32'hBBBB;
    step();
    md_valid = 0;
    wb_addr = 3; wb_data = 32'hAAAA;
    chk("prio_pre_waddr", 32'(rf_waddr), 2);
    step();
    wb_valid = 0;
    chk("prio_wb_waddr", 32'(rf_waddr), 3);
    chk("prio_wb_wdata", rf_wdata, 32'hAAAA);
    step();
    chk("prio_md_waddr", 32'(rf_waddr), 4);
    chk("prio_md_wdata", rf_wdata, 32'hBBBB);

    // Address-0 writes from both sources are suppressed
    wb_valid = 1; wb_addr = 0; wb_data = 32'h5555;
    step();
    wb_valid = 0;
    chk("zero_wb_we", 32'(rf_we), 0);
    md_valid = 1; md_addr = 0; md_data = 32'h6666;
    step();
    md_valid = 0;
    chk("zero_md_we_r1", 32'(rf_we), 0);
    step();
    chk("zero_md_we_r2", 32'(rf_we), 0);
    chk("zero_md_ready", 32'(md_ready), 1);

    // err via wb commit to a busy register
    src_a = 7;
    md_issue_valid = 1; md_issue_addr = 7;
    step();
    idle_inputs();
    chk("err_first_issue", 32'(err), 0);
    chk("err_busy7", 32'(busy_a), 1);
    wb_valid = 1; wb_addr = 7; wb_data = 32'h77;
    step();
    idle_inputs();
    chk("err_wb_busy", 32'(err), 1);
    step(); step();
    chk("err_sticky", 32'(err), 1);

    // Reset with two FIFO entries and busy bits
    src_a = 12; src_b = 7;
    wb_valid = 1; wb_addr = 1; wb_data = 32'h1;
    md_issue_valid = 1; md_issue_addr = 12;
    md_valid = 1; md_addr = 12; md_data = 32'hC12;
    step();
    md_issue_valid = 0;
    md_addr = 13; md_data = 32'hC13;
    chk("rst_pre_busy12", 32'(busy_a), 1);
    step();
    chk("rst_pre_full", 32'(md_ready), 0);
    idle_inputs();
    rst = 1;
    #1;
    chk("rst_ready_comb", 32'(md_ready), 0);
    step();
    rst = 0;
    chk("rst_busy_a", 32'(busy_a), 0);
    chk("rst_busy_b", 32'(busy_b), 0);
    chk("rst_we", 32'(rf_we), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_hold", 32'(pipe_hold), 0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("rst_no_ghost_%0d", i), 32'(rf_we), 0);
    end
    chk("rst_ready_after", 32'(md_ready), 1);

    // err via double issue
    md_issue_valid = 1; md_issue_addr = 7; src_a = 7;
    step();
    chk("dbl_first", 32'(err), 0);
    step();
    md_issue_valid = 0;
    chk("dbl_second", 32'(err), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1);
  end

endmodule
